// File: rtl/fft_operand_fetch_if.sv
// ---------------------------------------------------------------------------
// fft_operand_fetch_if
// Bundles the data-path signals around the FFT operand fetch block:
//   - AGU address beats    : addr_a_valid/addr_a (even), addr_b_valid/addr_b (odd)
//   - dual-port memory read: mem_ren, mem_addr_a/b, mem_rdata_a/b
//   - operand stream       : out_valid, out_ready, out_data_a/b
// master : the fetch block (drives the memory read port and the operand stream)
// slave  : its environment (AGUs, data memory and butterfly)
// ---------------------------------------------------------------------------
interface fft_operand_fetch_if #(
  parameter int AGU_BITWIDTH = 16,
  parameter int DATA_WIDTH   = 32
);
  logic                    addr_a_valid;
  logic [AGU_BITWIDTH-1:0] addr_a;
  logic                    addr_b_valid;
  logic [AGU_BITWIDTH-1:0] addr_b;
  logic                    mem_ren;
  logic [AGU_BITWIDTH-1:0] mem_addr_a;
  logic [AGU_BITWIDTH-1:0] mem_addr_b;
  logic [DATA_WIDTH-1:0]   mem_rdata_a;
  logic [DATA_WIDTH-1:0]   mem_rdata_b;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_WIDTH-1:0]   out_data_a;
  logic [DATA_WIDTH-1:0]   out_data_b;

  modport master (
    input  addr_a_valid, addr_a, addr_b_valid, addr_b,
    input  mem_rdata_a, mem_rdata_b, out_ready,
    output mem_ren, mem_addr_a, mem_addr_b,
    output out_valid, out_data_a, out_data_b
  );

  modport slave (
    output addr_a_valid, addr_a, addr_b_valid, addr_b,
    output mem_rdata_a, mem_rdata_b, out_ready,
    input  mem_ren, mem_addr_a, mem_addr_b,
    input  out_valid, out_data_a, out_data_b
  );
endinterface

// File: rtl/fft_operand_fetch.sv
// ---------------------------------------------------------------------------
// fft_operand_fetch
// Converts paired even/odd AGU address beats into dual-port memory reads,
// captures the returned operand pairs one cycle later into a small FIFO and
// presents them to the butterfly with valid/ready. Upstream is never stalled:
// a return that finds the FIFO full is dropped and flagged (overflow), and
// malformed or out-of-burst address beats are flagged (pair_error).
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start, burst_len  begin a burst of burst_len pairs (0 means 1), IDLE only
//   clear             synchronous flush of everything, back to IDLE
//   bus               address / memory / operand-stream bundle (master side)
//   fifo_count        FIFO occupancy
//   busy, done        burst in progress; pulse on the final pop of a burst
//   overflow          sticky, return dropped on a full FIFO
//   pair_error        sticky, unpaired valid or pair outside RUN
// ---------------------------------------------------------------------------
module fft_operand_fetch #(
  parameter int AGU_BITWIDTH = 16,
  parameter int DATA_WIDTH   = 32,
  parameter int FIFO_DEPTH   = 4,
  parameter int BURST_WIDTH  = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [BURST_WIDTH-1:0]         burst_len,
  input  logic                           clear,
  fft_operand_fetch_if.master            bus,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_count,
  output logic                           busy,
  output logic                           done,
  output logic                           overflow,
  output logic                           pair_error
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

  state_t                 state_q, state_d;
  logic                   pending_q, pending_d;
  logic [BURST_WIDTH-1:0] burst_len_q, burst_len_d;
  logic [BURST_WIDTH-1:0] issue_cnt_q, issue_cnt_d;
  logic [BURST_WIDTH-1:0] pop_cnt_q, pop_cnt_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   overflow_q, overflow_d;
  logic                   pair_error_q, pair_error_d;

  // Operand pair storage, {even, odd}; contents need no reset because
  // occupancy alone decides what is visible.
  logic [2*DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];

  logic ren, pop, push, full, both_valid, one_valid;

  always_comb begin
    both_valid = bus.addr_a_valid & bus.addr_b_valid;
    one_valid  = bus.addr_a_valid ^ bus.addr_b_valid;
    ren        = both_valid & (state_q == ST_RUN) & ~clear;
    full       = (count_q == CNT_W'(FIFO_DEPTH));
    pop        = (count_q != '0) & bus.out_ready & ~clear;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push       = pending_q & ~clear & (~full | pop);

    state_d      = state_q;
    pending_d    = ren;
    burst_len_d  = burst_len_q;
    issue_cnt_d  = issue_cnt_q;
    pop_cnt_d    = pop_cnt_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    overflow_d   = overflow_q;
    pair_error_d = pair_error_q;
    done         = 1'b0;

    if (clear) begin
      state_d      = ST_IDLE;
      pending_d    = 1'b0;
      issue_cnt_d  = '0;
      pop_cnt_d    = '0;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      overflow_d   = 1'b0;
      pair_error_d = 1'b0;
    end else begin
      if (pending_q & full & ~pop)
        overflow_d = 1'b1;
      if (one_valid | (both_valid & (state_q != ST_RUN)))
        pair_error_d = 1'b1;
      if (push)
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      if (ren)
        issue_cnt_d = issue_cnt_q + BURST_WIDTH'(1);
      if (pop & (state_q != ST_IDLE))
        pop_cnt_d = pop_cnt_q + BURST_WIDTH'(1);

      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d     = ST_RUN;
            burst_len_d = (burst_len == '0) ? BURST_WIDTH'(1) : burst_len;
            issue_cnt_d = '0;
            pop_cnt_d   = '0;
          end
        end
        ST_RUN: begin
          if (issue_cnt_d == burst_len_q)
            state_d = ST_DRAIN;
        end
        ST_DRAIN: begin
          // Dropped pairs keep pop_cnt short of burst_len: parks here until clear.
          if (pop & (pop_cnt_d == burst_len_q)) begin
            state_d = ST_IDLE;
            done    = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pending_q    <= 1'b0;
      burst_len_q  <= '0;
      issue_cnt_q  <= '0;
      pop_cnt_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      pair_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      burst_len_q  <= burst_len_d;
      issue_cnt_q  <= issue_cnt_d;
      pop_cnt_q    <= pop_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      pair_error_q <= pair_error_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr_q] <= {bus.mem_rdata_a, bus.mem_rdata_b};
  end

  logic [2*DATA_WIDTH-1:0] head;

  always_comb begin
    // Head is forced to zero while empty so the stream outputs read 0 in reset.
    head = (count_q != '0) ? fifo_mem[rd_ptr_q] : '0;
  end

  assign bus.mem_ren    = ren;
  assign bus.mem_addr_a = bus.addr_a;
  assign bus.mem_addr_b = bus.addr_b;
  assign bus.out_valid  = (count_q != '0);
  assign bus.out_data_a = head[2*DATA_WIDTH-1:DATA_WIDTH];
  assign bus.out_data_b = head[DATA_WIDTH-1:0];
  assign fifo_count     = count_q;
  assign busy           = (state_q != ST_IDLE);
  assign overflow       = overflow_q;
  assign pair_error     = pair_error_q;
endmodule
